// File: rtl/nand_bus_sequencer_if.sv
// Controller-core side of the NAND bus sequencer.
// The core (master) issues operations, supplies write beats and receives read beats.
// The sequencer (slave) reports completion through done/err.
interface nand_bus_sequencer_if #(
    parameter int DIOWidth = 16
);
    logic                req_valid;
    logic                req_ready;
    logic [DIOWidth-1:0] req_cmd;
    logic [DIOWidth-1:0] req_addr;
    logic [DIOWidth-1:0] wr_data;
    logic                wr_valid;
    logic                wr_ready;
    logic [DIOWidth-1:0] rd_data;
    logic                rd_valid;
    logic                done;
    logic                err;

    modport master (
        output req_valid, req_cmd, req_addr, wr_data, wr_valid,
        input  req_ready, wr_ready, rd_data, rd_valid, done, err
    );

    modport slave (
        input  req_valid, req_cmd, req_addr, wr_data, wr_valid,
        output req_ready, wr_ready, rd_data, rd_valid, done, err
    );
endinterface

// File: rtl/nand_bus_sequencer.sv
// NAND bus sequencer.
// Takes one erase / program-page / page-read operation at a time from the core and
// serialises it onto the memory's multiplexed DIO bus:
//   command latch -> address latch -> data phase -> status wait -> done.
// Strobes and latch data are registered against the next state, so every pin changes
// together with the state register.
// The one exception is the write beat, which is forwarded in the same cycle the core
// offers it so that the beat stays inside the WRITE window.
module nand_bus_sequencer #(
    parameter int DIOWidth      = 16,
    parameter int PageWords     = 2048,
    parameter int StatusTimeout = 65535
) (
    input  logic                clk,
    input  logic                rst_n,
    nand_bus_sequencer_if.slave core,
    output logic                cEn,
    output logic                CLE,
    output logic                ALE,
    output logic                WE,
    output logic                RE,
    inout  wire  [DIOWidth-1:0] DIO,
    input  logic                status
);

    localparam int BeatW = $clog2(PageWords) + 1;
    localparam int TmoW  = $clog2(StatusTimeout + 1);

    localparam logic [DIOWidth-1:0] CmdErase   = DIOWidth'(32'h0);
    localparam logic [DIOWidth-1:0] CmdProgram = DIOWidth'(32'h1);
    localparam logic [DIOWidth-1:0] CmdRead    = DIOWidth'(32'h2);

    localparam logic [BeatW-1:0] BeatLast = BeatW'(PageWords - 1);
    localparam logic [TmoW-1:0]  TmoLast  = TmoW'(StatusTimeout - 1);

    typedef enum logic [2:0] {
        S_IDLE        = 3'd0,
        S_CMD         = 3'd1,
        S_ADDR        = 3'd2,
        S_WRITE       = 3'd3,
        S_READ        = 3'd4,
        S_READ_TAIL   = 3'd5,
        S_WAIT_STATUS = 3'd6,
        S_DONE        = 3'd7
    } state_t;

    // Only the three defined opcodes start a memory transaction.
    function automatic logic is_legal_cmd(input logic [DIOWidth-1:0] cmd);
        return (cmd == CmdErase) || (cmd == CmdProgram) || (cmd == CmdRead);
    endfunction

    state_t              r_state;
    state_t              w_next_state;
    logic                w_next_err;

    logic [DIOWidth-1:0] r_cmd;
    logic [DIOWidth-1:0] r_addr;
    logic [BeatW-1:0]    r_beat;
    logic [BeatW-1:0]    w_next_beat;
    logic [TmoW-1:0]     r_tmo;

    logic                r_cen;
    logic                r_cle;
    logic                r_ale;
    logic                r_we;
    logic                r_re;
    logic                r_re_q;
    logic                r_dio_oe;
    logic [DIOWidth-1:0] r_dio;
    logic [DIOWidth-1:0] r_rd_data;
    logic                r_rd_valid;
    logic                r_done;
    logic                r_err;

    logic                w_wr_beat;
    logic                w_dio_oe;
    logic [DIOWidth-1:0] w_dio_out;

    // A write beat is taken on any WRITE cycle where the core has data.
    // Leaving WRITE on the last beat is what refuses any extra beats.
    assign w_wr_beat = (r_state == S_WRITE) && core.wr_valid;

    // Advance the sequencer state on every rising edge.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    // Next-state decode; err is only meaningful on transitions into DONE.
    always_comb begin
        w_next_state = r_state;
        w_next_err   = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (core.req_valid) begin
                    if (is_legal_cmd(core.req_cmd)) begin
                        w_next_state = S_CMD;
                    end else begin
                        w_next_state = S_DONE;
                        w_next_err   = 1'b1;
                    end
                end else begin
                    w_next_state = S_IDLE;
                end
            end
            S_CMD: begin
                w_next_state = S_ADDR;
            end
            S_ADDR: begin
                if (r_cmd == CmdProgram) begin
                    w_next_state = S_WRITE;
                end else if (r_cmd == CmdRead) begin
                    w_next_state = S_READ;
                end else begin
                    w_next_state = S_WAIT_STATUS;
                end
            end
            S_WRITE: begin
                if (w_wr_beat && (r_beat == BeatLast)) begin
                    w_next_state = S_WAIT_STATUS;
                end else begin
                    w_next_state = S_WRITE;
                end
            end
            S_READ: begin
                if (r_beat == BeatLast) begin
                    w_next_state = S_READ_TAIL;
                end else begin
                    w_next_state = S_READ;
                end
            end
            S_READ_TAIL: begin
                w_next_state = S_WAIT_STATUS;
            end
            S_WAIT_STATUS: begin
                if (status) begin
                    w_next_state = S_DONE;
                end else if (r_tmo == TmoLast) begin
                    w_next_state = S_DONE;
                    w_next_err   = 1'b1;
                end else begin
                    w_next_state = S_WAIT_STATUS;
                end
            end
            S_DONE: begin
                w_next_state = S_IDLE;
            end
            default: begin
                w_next_state = S_IDLE;
            end
        endcase
    end

    // Beat counter: steps once per accepted write beat or per RE cycle.
    // It is held at zero outside the data phases, so every page starts at beat 0.
    always_comb begin
        w_next_beat = r_beat;
        if (r_state == S_WRITE) begin
            if (w_wr_beat) begin
                w_next_beat = r_beat + BeatW'(1);
            end else begin
                w_next_beat = r_beat;
            end
        end else if (r_state == S_READ) begin
            w_next_beat = r_beat + BeatW'(1);
        end else begin
            w_next_beat = {BeatW{1'b0}};
        end
    end

    // Capture the accepted request; held for the whole operation.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cmd  <= {DIOWidth{1'b0}};
            r_addr <= {DIOWidth{1'b0}};
        end else if ((r_state == S_IDLE) && core.req_valid) begin
            r_cmd  <= core.req_cmd;
            r_addr <= core.req_addr;
        end else begin
            r_cmd  <= r_cmd;
            r_addr <= r_addr;
        end
    end

    // Beat and status-timeout counters.
    // The timeout counter counts completed WAIT_STATUS cycles and is zero on entry.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_beat <= {BeatW{1'b0}};
            r_tmo  <= {TmoW{1'b0}};
        end else begin
            r_beat <= w_next_beat;
            if (r_state == S_WAIT_STATUS) begin
                r_tmo <= r_tmo + TmoW'(1);
            end else begin
                r_tmo <= {TmoW{1'b0}};
            end
        end
    end

    // Memory strobes and latch data, registered from the next state so they line up with it.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cen    <= 1'b0;
            r_cle    <= 1'b0;
            r_ale    <= 1'b0;
            r_we     <= 1'b0;
            r_re     <= 1'b0;
            r_dio_oe <= 1'b0;
            r_dio    <= {DIOWidth{1'b0}};
        end else begin
            r_cen    <= (w_next_state != S_IDLE) && (w_next_state != S_DONE);
            r_cle    <= (w_next_state == S_CMD);
            r_ale    <= (w_next_state == S_ADDR);
            r_we     <= (w_next_state == S_CMD) || (w_next_state == S_ADDR);
            r_re     <= (w_next_state == S_READ);
            r_dio_oe <= (w_next_state == S_CMD) || (w_next_state == S_ADDR);
            if (w_next_state == S_CMD) begin
                r_dio <= core.req_cmd;
            end else if (w_next_state == S_ADDR) begin
                r_dio <= r_addr;
            end else begin
                r_dio <= {DIOWidth{1'b0}};
            end
        end
    end

    // Read capture: the memory answers one cycle after RE.
    // That data is registered here, so rd_valid lands two cycles after RE.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_re_q     <= 1'b0;
            r_rd_valid <= 1'b0;
            r_rd_data  <= {DIOWidth{1'b0}};
        end else begin
            r_re_q     <= r_re;
            r_rd_valid <= r_re_q;
            if (r_re_q) begin
                r_rd_data <= DIO;
            end else begin
                r_rd_data <= r_rd_data;
            end
        end
    end

    // Completion pulse and its error qualifier.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_done <= 1'b0;
            r_err  <= 1'b0;
        end else begin
            r_done <= (w_next_state == S_DONE);
            r_err  <= (w_next_state == S_DONE) && w_next_err;
        end
    end

    // DIO is driven by the latch cycles or by a live write beat, never anywhere else.
    assign w_dio_oe  = r_dio_oe || w_wr_beat;
    assign w_dio_out = w_wr_beat ? core.wr_data : r_dio;
    assign DIO       = w_dio_oe ? w_dio_out : {DIOWidth{1'bz}};

    assign cEn = r_cen;
    assign CLE = r_cle;
    assign ALE = r_ale;
    assign WE  = r_we || w_wr_beat;
    assign RE  = r_re;

    assign core.req_ready = (r_state == S_IDLE);
    assign core.wr_ready  = (r_state == S_WRITE);
    assign core.rd_data   = r_rd_data;
    assign core.rd_valid  = r_rd_valid;
    assign core.done      = r_done;
    assign core.err       = r_err;

endmodule
